// File: rtl/run_sequencer.sv
// Run-level sequencer: core reset/PC enable, watchdog, cycle counter
// and ownership mux for the single dat_mem port.
module run_sequencer #(
    parameter int D          = 10,
    parameter int DONE_PC    = 381,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 60000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [7:0]    host_addr,
    input  logic [7:0]    host_wdata,
    output logic          host_gnt,
    input  logic [D-1:0]  prog_ctr,
    input  logic          core_wr_en,
    input  logic          core_rd_en,
    input  logic [7:0]    core_addr,
    input  logic [7:0]    core_wdata,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          pc_en,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [D-1:0]  END_PC  = D'(DONE_PC);
    localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t state;
    logic   host_own;
    logic   core_own;

    // Run-level state machine with registered control outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc_en       <= 1'b0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !host_req) begin
                        state       <= RUN;
                        pc_en       <= 1'b1;
                        core_rst    <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                    end
                end
                RUN: begin
                    if (cycle_count != CNT_MAX)
                        cycle_count <= cycle_count + CW'(1);
                    if (prog_ctr == END_PC) begin
                        state <= DRAIN;
                        pc_en <= 1'b0;
                    end else if (cycle_count == WD_LAST) begin
                        state   <= DONE;
                        pc_en   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    if (!start) begin
                        state    <= IDLE;
                        core_rst <= 1'b1;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory ownership; reset forces no owner so nothing reaches dat_mem
    always_comb begin
        host_own  = 1'b0;
        core_own  = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        if (reset) begin
            host_own = host_req && (state == IDLE || state == DONE);
            core_own = (state == RUN) || (state == DRAIN);
        end
        if (host_own) begin
            mem_wr_en = host_we;
            mem_rd_en = !host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (core_own) begin
            mem_wr_en = core_wr_en && (pc_en || state == DRAIN);
            mem_rd_en = core_rd_en;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    assign host_gnt = host_own;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: vector table, hand-written
// run/watchdog/reset/restart sequences, and a randomized model check.
module tb_run_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, start_wd;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic [9:0] prog_ctr, prog_ctr_wd;
    logic       core_wr_en, core_rd_en;
    logic [7:0] core_addr, core_wdata;

    logic        host_gnt, mem_wr_en, mem_rd_en;
    logic [7:0]  mem_addr, mem_wdata;
    logic        pc_en, core_rst, busy, done, timeout;
    logic [15:0] cycle_count;

    logic        w_gnt, w_mw, w_mr;
    logic [7:0]  w_ma, w_md;
    logic        w_pc_en, w_core_rst, w_busy, w_done, w_timeout;
    logic [15:0] w_count;

    run_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .prog_ctr(prog_ctr),
        .core_wr_en(core_wr_en), .core_rd_en(core_rd_en),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc_en(pc_en), .core_rst(core_rst), .busy(busy),
        .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    run_sequencer #(.MAX_CYCLES(50)) dut_wd (
        .clk(clk), .reset(reset), .start(start_wd),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(w_gnt), .prog_ctr(prog_ctr_wd),
        .core_wr_en(core_wr_en), .core_rd_en(core_rd_en),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .mem_wr_en(w_mw), .mem_rd_en(w_mr),
        .mem_addr(w_ma), .mem_wdata(w_md),
        .pc_en(w_pc_en), .core_rst(w_core_rst), .busy(w_busy),
        .done(w_done), .timeout(w_timeout), .cycle_count(w_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       st, hr, hw;
        logic [7:0] ha, hd;
        logic       cw, cr;
        logic [7:0] ca, cd;
        logic [9:0] pc;
        logic       gnt, mw, mr;
        logic [7:0] ma, md;
        logic       pe, crst, bz, dn;
    } vec_t;

    vec_t vt[11];

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_t;

    initial begin
        mphase_t ph;
        int      mcnt;
        bit      mto;
        int      pc, k381, kd, drains, wdrain;
        bit      en, hown, cown;

        reset = 1'b0; start = 1'b0; start_wd = 1'b0;
        host_req = 1'b1; host_we = 1'b1;
        host_addr = 8'h10; host_wdata = 8'hA5;
        prog_ctr = '0; prog_ctr_wd = 10'd5;
        core_wr_en = 1'b1; core_rd_en = 1'b1;
        core_addr = 8'h20; core_wdata = 8'h77;

        // reset state with active requests on every input
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc_en", pc_en, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", cycle_count, 0);
        check("rst_gnt", host_gnt, 0);
        check("rst_mem_wr", mem_wr_en, 0);
        check("rst_mem_rd", mem_rd_en, 0);
        @(negedge clk);
        reset = 1'b1;

        vt[0]  = '{0,1,1,8'h10,8'hA5,0,0,8'h00,8'h00,10'd0,
                   1,1,0,8'h10,8'hA5,0,1,0,0};
        vt[1]  = '{0,1,0,8'h11,8'h3C,1,1,8'h20,8'h55,10'd0,
                   1,0,1,8'h11,8'h3C,0,1,0,0};
        vt[2]  = '{1,1,1,8'h12,8'h33,1,0,8'h20,8'h55,10'd0,
                   1,1,0,8'h12,8'h33,0,1,0,0};
        vt[3]  = '{1,0,1,8'h12,8'h33,1,1,8'h20,8'h55,10'd0,
                   0,0,0,8'h00,8'h00,0,1,0,0};
        vt[4]  = '{1,1,1,8'h10,8'hA5,1,0,8'h20,8'h77,10'd0,
                   0,1,0,8'h20,8'h77,1,0,1,0};
        vt[5]  = '{1,0,0,8'h00,8'h00,0,1,8'h30,8'h11,10'd381,
                   0,0,1,8'h30,8'h11,1,0,1,0};
        vt[6]  = '{1,1,1,8'h10,8'hA5,1,0,8'h40,8'h88,10'd382,
                   0,1,0,8'h40,8'h88,0,0,1,0};
        vt[7]  = '{1,1,0,8'h50,8'h99,1,1,8'h40,8'h88,10'd382,
                   1,0,1,8'h50,8'h99,0,0,0,1};
        vt[8]  = '{1,0,0,8'h50,8'h99,1,1,8'h40,8'h88,10'd382,
                   0,0,0,8'h00,8'h00,0,0,0,1};
        vt[9]  = '{0,0,0,8'h50,8'h99,1,1,8'h40,8'h88,10'd382,
                   0,0,0,8'h00,8'h00,0,0,0,1};
        vt[10] = '{0,0,0,8'h50,8'h99,1,1,8'h40,8'h88,10'd0,
                   0,0,0,8'h00,8'h00,0,1,0,0};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = vt[i].st; host_req = vt[i].hr; host_we = vt[i].hw;
            host_addr = vt[i].ha; host_wdata = vt[i].hd;
            core_wr_en = vt[i].cw; core_rd_en = vt[i].cr;
            core_addr = vt[i].ca; core_wdata = vt[i].cd;
            prog_ctr = vt[i].pc;
            #1;
            check($sformatf("v%0d_gnt", i), host_gnt, vt[i].gnt);
            check($sformatf("v%0d_mw", i), mem_wr_en, vt[i].mw);
            check($sformatf("v%0d_mr", i), mem_rd_en, vt[i].mr);
            check($sformatf("v%0d_ma", i), mem_addr, vt[i].ma);
            check($sformatf("v%0d_md", i), mem_wdata, vt[i].md);
            check($sformatf("v%0d_pe", i), pc_en, vt[i].pe);
            check($sformatf("v%0d_crst", i), core_rst, vt[i].crst);
            check($sformatf("v%0d_busy", i), busy, vt[i].bz);
            check($sformatf("v%0d_done", i), done, vt[i].dn);
            if (i == 8) begin
                check("v8_count", cycle_count, 2);
                check("v8_timeout", timeout, 0);
            end
        end

        // normal run with a core PC that advances under pc_en
        @(negedge clk);
        start = 1'b1; host_req = 1'b0; host_we = 1'b0;
        core_wr_en = 1'b0; core_rd_en = 1'b0;
        pc = 0; prog_ctr = '0;
        @(posedge clk);
        #1;
        check("run_start_latency", pc_en, 1);
        k381 = -100; kd = -1; drains = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            prog_ctr = 10'(pc);
            #1;
            if (busy && !pc_en) drains++;
            if (pc_en && prog_ctr == 10'd381) k381 = k;
            if (done) begin
                kd = k;
                break;
            end
            en = pc_en;
            @(posedge clk);
            if (en) pc++;
        end
        check("run_done", done, 1);
        check("run_timeout", timeout, 0);
        check("run_count", cycle_count, 382);
        check("run_drain_cycles", drains, 1);
        check("run_done_latency", kd - k381, 2);

        // start held high: no auto-restart
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("hold_done", done, 1);
            check("hold_pc_en", pc_en, 0);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("back_idle_done", done, 0);
        check("back_idle_crst", core_rst, 1);
        check("back_idle_count", cycle_count, 382);
        start = 1'b1; prog_ctr = '0;
        @(negedge clk);
        #1;
        check("restart_count0", cycle_count, 0);
        check("restart_pc_en", pc_en, 1);
        repeat (10) @(negedge clk);
        #1;
        check("restart_count10", cycle_count, 10);

        // asynchronous reset mid-run with a core store pending
        core_wr_en = 1'b1; host_req = 1'b1; host_we = 1'b1;
        #1;
        check("pre_rst_mem_wr", mem_wr_en, 1);
        reset = 1'b0;
        #1;
        check("arst_mem_wr", mem_wr_en, 0);
        check("arst_gnt", host_gnt, 0);
        check("arst_pc_en", pc_en, 0);
        check("arst_crst", core_rst, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_count", cycle_count, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_gnt", host_gnt, 1);

        // watchdog on the 50-cycle instance, PC stuck at 5
        @(negedge clk);
        host_req = 1'b0; core_wr_en = 1'b0;
        start_wd = 1'b1;
        wdrain = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (w_busy && !w_pc_en) wdrain++;
            if (w_done) break;
        end
        check("wd_done", w_done, 1);
        check("wd_timeout", w_timeout, 1);
        check("wd_count", w_count, 50);
        check("wd_no_drain", wdrain, 0);
        start_wd = 1'b0;
        @(negedge clk);
        #1;
        check("wd_clear", w_timeout, 0);

        // randomized traffic against the run-level model
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ph = M_IDLE; mcnt = 0; mto = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            host_req = ($urandom_range(0, 2) == 0);
            host_we = 1'($urandom_range(0, 1));
            host_addr = 8'($urandom); host_wdata = 8'($urandom);
            core_wr_en = 1'($urandom_range(0, 1));
            core_rd_en = 1'($urandom_range(0, 1));
            core_addr = 8'($urandom); core_wdata = 8'($urandom);
            prog_ctr = ($urandom_range(0, 15) == 0) ? 10'd381
                                                   : 10'($urandom_range(0, 380));
            #1;
            hown = host_req && (ph == M_IDLE || ph == M_DONE);
            cown = (ph == M_RUN || ph == M_DRAIN);
            check("r_gnt", host_gnt, hown);
            check("r_mw", mem_wr_en,
                  hown ? host_we : (cown ? core_wr_en : 1'b0));
            check("r_mr", mem_rd_en,
                  hown ? !host_we : (cown ? core_rd_en : 1'b0));
            check("r_ma", mem_addr,
                  hown ? host_addr : (cown ? core_addr : 8'h00));
            check("r_md", mem_wdata,
                  hown ? host_wdata : (cown ? core_wdata : 8'h00));
            check("r_pe", pc_en, ph == M_RUN);
            check("r_crst", core_rst, ph == M_IDLE);
            check("r_busy", busy, cown);
            check("r_done", done, ph == M_DONE);
            check("r_to", timeout, mto);
            check("r_cnt", cycle_count, mcnt);
            @(posedge clk);
            case (ph)
                M_IDLE:
                    if (start && !host_req) begin
                        ph = M_RUN; mcnt = 0; mto = 1'b0;
                    end
                M_RUN: begin
                    if (mcnt < 65535) mcnt++;
                    if (prog_ctr == 10'd381) ph = M_DRAIN;
                    else if (mcnt >= 60000) begin
                        ph = M_DONE; mto = 1'b1;
                    end
                end
                M_DRAIN: ph = M_DONE;
                M_DONE:
                    if (!start) begin
                        ph = M_IDLE; mto = 1'b0;
                    end
                default: ph = M_IDLE;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
